// File: rtl/key_sw_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : key_sw_conditioner_if
// Description : Signal bundle between the raw DE10-Lite board inputs and the
//               unit logic. The master side drives the raw KEY/SW pins; the
//               slave side (the conditioner) returns the clean versions.
//   KEY         [1:0] raw push-buttons, active-low, asynchronous
//   SW          [9:0] raw slide switches, asynchronous
//   KEY_DOWN    [1:0] debounced level, 1 = key held
//   KEY_PRESS   [1:0] one-cycle pulse on debounced press
//   KEY_RELEASE [1:0] one-cycle pulse on debounced release
//   SW_SYNC     [9:0] synchronized switch value
//   SW_CHG            one-cycle pulse when SW_SYNC takes a new value
// Revision    : 1.0 - initial release
// ============================================================================
interface key_sw_conditioner_if;
  logic [1:0] KEY;
  logic [9:0] SW;
  logic [1:0] KEY_DOWN;
  logic [1:0] KEY_PRESS;
  logic [1:0] KEY_RELEASE;
  logic [9:0] SW_SYNC;
  logic       SW_CHG;

  modport master (
    output KEY, SW,
    input  KEY_DOWN, KEY_PRESS, KEY_RELEASE, SW_SYNC, SW_CHG
  );

  modport slave (
    input  KEY, SW,
    output KEY_DOWN, KEY_PRESS, KEY_RELEASE, SW_SYNC, SW_CHG
  );
endinterface
`default_nettype wire

// File: rtl/key_sw_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : key_sw_conditioner
// Description : Board-input front end. Synchronizes KEY[1:0] and SW[9:0] into
//               the MAX10_CLK1_50 domain, debounces each key with an
//               independent four-state FSM (press/release pulses coincide
//               with the KEY_DOWN change) and flags switch changes with a
//               one-cycle SW_CHG strobe. All outputs are registered.
// Ports       : MAX10_CLK1_50 - system clock (rising edge)
//               RESET_N       - asynchronous active-low reset
//               bus           - key_sw_conditioner_if.slave (raw in, clean out)
// Parameters  : DEBOUNCE_CYCLES - stable cycles before a key flips (>= 1)
//               CNT_W           - counter width, 2**CNT_W > DEBOUNCE_CYCLES
// Revision    : 1.0 - initial release
// ============================================================================
module key_sw_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input wire                  MAX10_CLK1_50,
  input wire                  RESET_N,
  key_sw_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] c_deb_max = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_UP        = 2'd0,
    ST_UP_PEND   = 2'd1,
    ST_DOWN      = 2'd2,
    ST_DOWN_PEND = 2'd3
  } key_state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchronizers. Key flops reset to 1 (released) so that leaving
  // reset never looks like a press edge.
  // --------------------------------------------------------------------------
  logic [1:0] r_key_s1, r_key_s2;
  logic [9:0] r_sw_s1, r_sw_s2;
  logic       r_sw_chg;
  logic [1:0] w_ks;

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_key_s1 <= 2'b11;
      r_key_s2 <= 2'b11;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_sw_chg <= 1'b0;
    end else begin
      r_key_s1 <= bus.KEY;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= bus.SW;
      r_sw_s2  <= r_sw_s1;
      // Registered alongside r_sw_s2 so the strobe lines up with the new value.
      r_sw_chg <= (r_sw_s1 != r_sw_s2);
    end
  end

  // Keys are active-low on the board; the FSMs work in "1 = pressed".
  assign w_ks = ~r_key_s2;

  // --------------------------------------------------------------------------
  // Per-key debounce FSM. The counter tracks how many consecutive cycles the
  // synchronized input has disagreed with the reported level; it restarts on
  // any bounce and stops at DEBOUNCE_CYCLES, so it can never wrap.
  // --------------------------------------------------------------------------
  logic [1:0] w_key_down, w_key_press, w_key_rel;

  for (genvar gi = 0; gi < 2; gi++) begin : g_key
    key_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_down;
    logic             r_press;
    logic             r_rel;

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        r_state <= ST_UP;
        r_cnt   <= '0;
        r_down  <= 1'b0;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
      end else begin
        r_press <= 1'b0;
        r_rel   <= 1'b0;
        case (r_state)
          ST_UP: begin
            if (w_ks[gi]) begin
              r_state <= ST_UP_PEND;
              r_cnt   <= c_cnt_one;
            end
          end
          ST_UP_PEND: begin
            if (!w_ks[gi]) begin
              r_state <= ST_UP;
              r_cnt   <= '0;
            end else if (r_cnt == c_deb_max) begin
              r_state <= ST_DOWN;
              r_cnt   <= '0;
              r_down  <= 1'b1;
              r_press <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end
          ST_DOWN: begin
            if (!w_ks[gi]) begin
              r_state <= ST_DOWN_PEND;
              r_cnt   <= c_cnt_one;
            end
          end
          ST_DOWN_PEND: begin
            if (w_ks[gi]) begin
              r_state <= ST_DOWN;
              r_cnt   <= '0;
            end else if (r_cnt == c_deb_max) begin
              r_state <= ST_UP;
              r_cnt   <= '0;
              r_down  <= 1'b0;
              r_rel   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end
          default: begin
            r_state <= ST_UP;
            r_cnt   <= '0;
          end
        endcase
      end
    end

    assign w_key_down[gi]  = r_down;
    assign w_key_press[gi] = r_press;
    assign w_key_rel[gi]   = r_rel;
  end

  assign bus.KEY_DOWN    = w_key_down;
  assign bus.KEY_PRESS   = w_key_press;
  assign bus.KEY_RELEASE = w_key_rel;
  assign bus.SW_SYNC     = r_sw_s2;
  assign bus.SW_CHG      = r_sw_chg;

endmodule
`default_nettype wire

// File: tb/tb_key_sw_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_sw_conditioner
// Description : Self-checking bench for key_sw_conditioner (DEBOUNCE_CYCLES=4).
//               The reference model keeps a history of raw pin samples: a key
//               flips when the last DEBOUNCE_CYCLES+1 values its FSM has seen
//               all disagree with the reported level; switches are the raw
//               history delayed by two samples.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_sw_conditioner;

  localparam int DEB  = 4;
  localparam int HLEN = DEB + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  key_sw_conditioner_if bus ();

  key_sw_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3)
  ) dut (
    .MAX10_CLK1_50(clk),
    .RESET_N      (rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: index 0 is the newest raw sample.
  logic [1:0] m_key_hist [HLEN];
  logic [9:0] m_sw_hist  [3];
  logic [1:0] m_level;
  logic [1:0] m_press;
  logic [1:0] m_rel;
  logic [9:0] m_sync;
  logic       m_chg;
  int         obs_press [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < HLEN; k++) m_key_hist[k] = 2'b11;
    for (int k = 0; k < 3; k++) m_sw_hist[k] = '0;
    m_level = 2'b00;
    m_press = 2'b00;
    m_rel   = 2'b00;
    m_sync  = '0;
    m_chg   = 1'b0;
  endtask

  task automatic model_edge();
    logic all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = HLEN - 1; k > 0; k--) m_key_hist[k] = m_key_hist[k-1];
    m_key_hist[0] = bus.KEY;
    m_sw_hist[2] = m_sw_hist[1];
    m_sw_hist[1] = m_sw_hist[0];
    m_sw_hist[0] = bus.SW;
    m_press = 2'b00;
    m_rel   = 2'b00;
    for (int b = 0; b < 2; b++) begin
      // The FSM at this edge has seen raw samples 2..2+DEB edges old.
      all_diff = 1'b1;
      for (int k = 2; k <= 2 + DEB; k++)
        if ((~m_key_hist[k][b]) == m_level[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_level[b] = ~m_level[b];
        if (m_level[b]) m_press[b] = 1'b1;
        else            m_rel[b]   = 1'b1;
      end
    end
    m_sync = m_sw_hist[1];
    m_chg  = (m_sw_hist[1] != m_sw_hist[2]);
  endtask

  task automatic check_outputs();
    check("key_down",    32'(bus.KEY_DOWN),    32'(m_level));
    check("key_press",   32'(bus.KEY_PRESS),   32'(m_press));
    check("key_release", 32'(bus.KEY_RELEASE), 32'(m_rel));
    check("sw_sync",     32'(bus.SW_SYNC),     32'(m_sync));
    check("sw_chg",      32'(bus.SW_CHG),      32'(m_chg));
  endtask

  // One clock: model and DUT take the same edge, outputs compared on the
  // falling edge; the caller changes inputs afterwards.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    for (int b = 0; b < 2; b++) obs_press[b] += int'(bus.KEY_PRESS[b]);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called at a falling edge; reset takes effect without waiting for a clock.
  task automatic reset_pulse(input int cycles);
    rst_n = 1'b0;
    #1;
    check("rst_async_down",    32'(bus.KEY_DOWN),    32'h0);
    check("rst_async_press",   32'(bus.KEY_PRESS),   32'h0);
    check("rst_async_release", 32'(bus.KEY_RELEASE), 32'h0);
    check("rst_async_sw_sync", 32'(bus.SW_SYNC),     32'h0);
    check("rst_async_sw_chg",  32'(bus.SW_CHG),      32'h0);
    model_reset();
    steps(cycles);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.KEY = 2'b11;
    bus.SW  = 10'h151;
    rst_n   = 1'b0;
    obs_press[0] = 0;
    obs_press[1] = 0;
    model_reset();
    steps(3);
    rst_n = 1'b1;

    // Switch value captured during reset appears two edges later.
    steps(2);
    check("sw_sync_after_reset", 32'(bus.SW_SYNC), 32'h151);
    steps(3);

    // KEY[0] clean press and release.
    bus.KEY = 2'b10;
    steps(10);
    check("key0_held", 32'(bus.KEY_DOWN), 32'h1);
    bus.KEY = 2'b11;
    steps(10);

    // KEY[1] bounce shorter than the debounce window.
    obs_press[1] = 0;
    bus.KEY = 2'b01; steps(3);
    bus.KEY = 2'b11; steps(1);
    bus.KEY = 2'b01; steps(3);
    bus.KEY = 2'b11; steps(8);
    check("bounce_no_press", 32'(obs_press[1]), 32'd0);
    bus.KEY = 2'b01; steps(10);
    check("press_once", 32'(obs_press[1]), 32'd1);
    bus.KEY = 2'b11; steps(10);

    // Both keys on the same edge.
    bus.KEY = 2'b00; steps(10);
    bus.KEY = 2'b11; steps(10);

    // Reset in the middle of a pending count; key still held afterwards.
    bus.KEY = 2'b10; steps(3);
    obs_press[0] = 0;
    reset_pulse(2);
    check("no_press_in_reset", 32'(obs_press[0]), 32'd0);
    steps(10);
    check("press_after_reset", 32'(obs_press[0]), 32'd1);
    bus.KEY = 2'b11; steps(10);

    // Switch ramp, one new value every cycle, then steady.
    for (int v = 10'h00C; v <= 10'h166; v++) begin
      bus.SW = 10'(v);
      step();
    end
    steps(6);

    // Random phases: noisy, then calmer so debounced flips also occur.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 700; c++) begin
        if ($urandom_range(0, (ph % 2 == 0) ? 3 : 11) == 0)
          bus.KEY[$urandom_range(0, 1)] = ~bus.KEY[$urandom_range(0, 1)];
        if ($urandom_range(0, 9) == 0)
          bus.SW = 10'($urandom);
        if ($urandom_range(0, 399) == 0)
          reset_pulse($urandom_range(1, 3));
        else
          step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
